// File: rtl/arbitro_entrada_salida.sv
// arbitro_entrada_salida
// Two-requester round-robin arbiter and sequencer for the shared I/O port block.
// Requester 0 is the CPU datapath and requester 1 a secondary master. The winner's
// request is presented on the es_* port for one cycle. A read then waits one cycle
// for es_leido. The transaction completes with a one-cycle ack to the winner.
// Addresses at or above NUM_DISP never reach the port block. They are answered
// immediately with an error flag alongside the ack.
module arbitro_entrada_salida #(
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_DIR  = 7,
  parameter int NUM_DISP   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  // Requester 0 (CPU datapath)
  input  logic                  req0,
  input  logic                  escribir0,
  input  logic [ANCHO_DIR-1:0]  dir0,
  input  logic [ANCHO_DATO-1:0] dato0,
  output logic                  ack0,
  output logic [ANCHO_DATO-1:0] leido0,
  output logic                  error0,
  // Requester 1 (secondary master)
  input  logic                  req1,
  input  logic                  escribir1,
  input  logic [ANCHO_DIR-1:0]  dir1,
  input  logic [ANCHO_DATO-1:0] dato1,
  output logic                  ack1,
  output logic [ANCHO_DATO-1:0] leido1,
  output logic                  error1,
  // I/O port block
  output logic                  es_activar,
  output logic                  es_escribir,
  output logic [ANCHO_DIR-1:0]  es_dir,
  output logic [ANCHO_DATO-1:0] es_dato,
  input  logic [ANCHO_DATO-1:0] es_leido
);

  localparam logic [1:0] REPOSO    = 2'd0;
  localparam logic [1:0] ACCESO    = 2'd1;
  localparam logic [1:0] ESPERA    = 2'd2;
  localparam logic [1:0] RESPUESTA = 2'd3;

  localparam logic [ANCHO_DIR-1:0] DIR_LIMITE = ANCHO_DIR'(NUM_DISP);

  logic [1:0]            estado;
  logic                  puntero;      // requester favoured when both ask
  logic                  ganador;      // requester owning the current transaction
  logic                  op_escribir;  // latched operation of the current transaction

  logic                  gana1;
  logic                  sel_escribir;
  logic [ANCHO_DIR-1:0]  sel_dir;
  logic [ANCHO_DATO-1:0] sel_dato;
  logic                  sel_error;

  // Pick the winner among the active requests and select its request fields.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    gana1        = req1 && (!req0 || puntero);
    sel_escribir = gana1 ? escribir1 : escribir0;
    sel_dir      = gana1 ? dir1      : dir0;
    sel_dato     = gana1 ? dato1     : dato0;
    sel_error    = (sel_dir >= DIR_LIMITE);
  end

  // Transaction sequencer. It drives the registered port, ack, error and read-data outputs.
  // NOTE: all state here is updated with non-blocking assignments, so each branch sees
  // the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= REPOSO;
      puntero     <= 1'b0;
      ganador     <= 1'b0;
      op_escribir <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      error0      <= 1'b0;
      error1      <= 1'b0;
      leido0      <= '0;
      leido1      <= '0;
      es_activar  <= 1'b0;
      es_escribir <= 1'b0;
      es_dir      <= '0;
      es_dato     <= '0;
    end else begin
      // Pulsed outputs default low, and the port fields are zero outside ACCESO.
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      es_activar  <= 1'b0;
      es_escribir <= 1'b0;
      es_dir      <= '0;
      es_dato     <= '0;

      case (estado)
        REPOSO: begin
          if (req0 || req1) begin
            ganador     <= gana1;
            op_escribir <= sel_escribir;
            if (sel_error) begin
              // Unimplemented device: answer at once and skip the port block.
              estado <= RESPUESTA;
              ack0   <= !gana1;
              ack1   <= gana1;
              error0 <= !gana1;
              error1 <= gana1;
            end else begin
              estado      <= ACCESO;
              es_activar  <= 1'b1;
              es_escribir <= sel_escribir;
              es_dir      <= sel_dir;
              es_dato     <= sel_dato;
            end
          end
        end

        ACCESO: begin
          if (op_escribir) begin
            estado <= RESPUESTA;
            ack0   <= !ganador;
            ack1   <= ganador;
          end else begin
            estado <= ESPERA;
          end
        end

        ESPERA: begin
          // The device read data is valid in this cycle.
          estado <= RESPUESTA;
          ack0   <= !ganador;
          ack1   <= ganador;
          if (ganador) leido1 <= es_leido;
          else         leido0 <= es_leido;
        end

        RESPUESTA: begin
          estado  <= REPOSO;
          error0  <= 1'b0;
          error1  <= 1'b0;
          puntero <= !ganador;
        end

        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_entrada_salida.sv
// tb_arbitro_entrada_salida
// Randomised bench for the two-requester I/O arbiter. Each requester is driven by an
// agent that follows the req/ack handshake. A transaction-level reference model
// schedules the expected port activity, acks, errors and read data on a cycle timeline.
// A simple device model answers reads on the port block.
module tb_arbitro_entrada_salida;

  localparam int AD = 8;
  localparam int AR = 7;
  localparam int ND = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, escribir0 = 1'b0;
  logic [AR-1:0] dir0 = '0;
  logic [AD-1:0] dato0 = '0;
  logic          req1 = 1'b0, escribir1 = 1'b0;
  logic [AR-1:0] dir1 = '0;
  logic [AD-1:0] dato1 = '0;
  logic          ack0, error0, ack1, error1;
  logic [AD-1:0] leido0, leido1;
  logic          es_activar, es_escribir;
  logic [AR-1:0] es_dir;
  logic [AD-1:0] es_dato;
  logic [AD-1:0] es_leido = '0;

  arbitro_entrada_salida #(.ANCHO_DATO(AD), .ANCHO_DIR(AR), .NUM_DISP(ND)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .escribir0(escribir0), .dir0(dir0), .dato0(dato0),
    .ack0(ack0), .leido0(leido0), .error0(error0),
    .req1(req1), .escribir1(escribir1), .dir1(dir1), .dato1(dato1),
    .ack1(ack1), .leido1(leido1), .error1(error1),
    .es_activar(es_activar), .es_escribir(es_escribir), .es_dir(es_dir),
    .es_dato(es_dato), .es_leido(es_leido)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          esc;
    bit [AR-1:0] dir;
    bit [AD-1:0] dato;
  } pet_t;

  // Expected outputs for one cycle.
  typedef struct {
    bit          act;
    bit          esc;
    bit [AR-1:0] dir;
    bit [AD-1:0] dato;
    bit [1:0]    ack;
    bit [1:0]    err;
    bit          upd;
    bit          w;
    bit [AD-1:0] leido;
  } exp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          chk_on = 1'b0;
  bit          rst_prev = 1'b0;

  exp_t        sched[int];
  exp_t        vacio;
  int          idle_at = 0;
  bit          ptr = 1'b0;
  bit [AD-1:0] leido_exp[2];
  bit [AD-1:0] mem_ref[128];
  bit [AD-1:0] mem_dev[128];
  bit          dev_rd = 1'b0;
  bit [AR-1:0] dev_rd_dir = '0;

  pet_t        cola0[$];
  pet_t        cola1[$];
  bit          activo[2];
  bit          concedido[2];
  bit          ack_visto[2];
  int          espera[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic pet_t pet(input bit esc, input int dir, input int dato);
    pet_t p;
    p.esc  = esc;
    p.dir  = AR'(dir);
    p.dato = AD'(dato);
    return p;
  endfunction

  function automatic pet_t pet_aleatoria();
    pet_t p;
    p.esc  = 1'($urandom_range(0, 1));
    p.dir  = ($urandom_range(0, 7) == 0) ? AR'($urandom_range(ND, 127))
                                         : AR'($urandom_range(0, ND - 1));
    p.dato = AD'($urandom);
    return p;
  endfunction

  task automatic poner(input int i, input bit r, input pet_t p);
    if (i == 0) begin
      req0 = r; escribir0 = p.esc; dir0 = p.dir; dato0 = p.dato;
    end else begin
      req1 = r; escribir1 = p.esc; dir1 = p.dir; dato1 = p.dato;
    end
  endtask

  // Requester agent: raise a queued request, hold it until ack, then drop it for one cycle.
  // Once granted it may drop req or scramble its fields, which must have no effect.
  task automatic agente(input int i, input bit rst);
    pet_t  p;
    bit    hay;
    string tag;
    p   = pet(1'b0, 0, 0);
    hay = 1'b0;
    if (rst) begin
      activo[i] = 0; concedido[i] = 0; ack_visto[i] = 0;
      poner(i, 1'b0, p);
    end else if (ack_visto[i]) begin
      tag = (i == 0) ? "latencia0" : "latencia1";
      check(tag, 32'(espera[i] <= 7), 32'd1);
      activo[i] = 0; concedido[i] = 0; ack_visto[i] = 0;
      poner(i, 1'b0, p);
    end else if (activo[i]) begin
      espera[i]++;
      if (espera[i] > 12) begin
        tag = (i == 0) ? "plazo_ack0" : "plazo_ack1";
        check(tag, 32'(espera[i]), 32'd12);
        activo[i] = 0; concedido[i] = 0;
        poner(i, 1'b0, p);
      end else if (concedido[i] && $urandom_range(0, 3) == 0) begin
        poner(i, 1'($urandom_range(0, 1)), pet_aleatoria());
      end
    end else begin
      if (i == 0 && cola0.size() > 0) begin p = cola0.pop_front(); hay = 1'b1; end
      if (i == 1 && cola1.size() > 0) begin p = cola1.pop_front(); hay = 1'b1; end
      if (hay) begin
        poner(i, 1'b1, p);
        activo[i] = 1; espera[i] = 0;
      end
    end
  endtask

  function automatic exp_t obtener(input int k);
    return sched.exists(k) ? sched[k] : vacio;
  endfunction

  // Reference model: when the arbiter is free and someone asks, decide the winner and
  // place the whole transaction on the timeline.
  task automatic modelo(input bit rst);
    bit   w;
    pet_t p;
    exp_t t;
    if (rst || cyc != idle_at) return;
    if (!(req0 || req1)) begin
      idle_at = cyc + 1;
      return;
    end
    w = (req0 && req1) ? ptr : req1;
    if (w) p = pet(escribir1, int'(dir1), int'(dato1));
    else   p = pet(escribir0, int'(dir0), int'(dato0));
    ptr = !w;
    concedido[w] = 1;
    if (int'(p.dir) >= ND) begin
      t = obtener(cyc + 1); t.ack[w] = 1; t.err[w] = 1; sched[cyc + 1] = t;
      idle_at = cyc + 2;
    end else begin
      t = obtener(cyc + 1);
      t.act = 1; t.esc = p.esc; t.dir = p.dir; t.dato = p.dato;
      sched[cyc + 1] = t;
      if (p.esc) begin
        mem_ref[p.dir] = p.dato;
        t = obtener(cyc + 2); t.ack[w] = 1; sched[cyc + 2] = t;
        idle_at = cyc + 3;
      end else begin
        t = obtener(cyc + 3);
        t.ack[w] = 1; t.upd = 1; t.w = w; t.leido = mem_ref[p.dir];
        sched[cyc + 3] = t;
        idle_at = cyc + 4;
      end
    end
  endtask

  // One clock cycle. Inputs are driven 1 time unit after the rising edge and
  // outputs are compared on the falling edge.
  task automatic ciclo(input bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
    es_leido = dev_rd ? mem_dev[dev_rd_dir] : AD'($urandom);
    dev_rd = 1'b0;
    agente(0, rst);
    agente(1, rst);
    modelo(rst);

    @(negedge clk);
    if (chk_on) begin
      e = obtener(cyc);
      sched.delete(cyc);
      if (rst_prev) begin leido_exp[0] = '0; leido_exp[1] = '0; end
      if (e.upd) leido_exp[e.w] = e.leido;
      check("es_activar",  32'(es_activar),  32'(e.act));
      check("es_escribir", 32'(es_escribir), 32'(e.esc));
      check("es_dir",      32'(es_dir),      32'(e.dir));
      check("es_dato",     32'(es_dato),     32'(e.dato));
      check("ack0",        32'(ack0),        32'(e.ack[0]));
      check("ack1",        32'(ack1),        32'(e.ack[1]));
      check("error0",      32'(error0),      32'(e.err[0]));
      check("error1",      32'(error1),      32'(e.err[1]));
      check("leido0",      32'(leido0),      32'(leido_exp[0]));
      check("leido1",      32'(leido1),      32'(leido_exp[1]));
    end
    // Device side: perform writes and queue read data for the next cycle.
    if (es_activar === 1'b1) begin
      if (es_escribir === 1'b1) mem_dev[es_dir] = es_dato;
      else begin dev_rd = 1'b1; dev_rd_dir = es_dir; end
    end
    if (activo[0] && ack0 === 1'b1) ack_visto[0] = 1;
    if (activo[1] && ack1 === 1'b1) ack_visto[1] = 1;
    if (rst) begin
      sched.delete();
      idle_at = cyc + 1;
      ptr = 1'b0;
      chk_on = 1'b1;
    end
    rst_prev = rst;
  endtask

  task automatic inactivo(input int n);
    for (int k = 0; k < n; k++) ciclo(1'b0);
  endtask

  initial begin
    bit [AD-1:0] v;
    vacio = '{default: 0};
    leido_exp[0] = '0;
    leido_exp[1] = '0;
    for (int i = 0; i < 128; i++) begin
      v = AD'($urandom);
      mem_ref[i] = v;
      mem_dev[i] = v;
    end
    mem_ref[4] = 8'h3C;
    mem_dev[4] = 8'h3C;

    // Reset for two clocks, then everything idle and zero.
    ciclo(1'b1);
    ciclo(1'b1);
    inactivo(2);

    // A write by requester 0 leaves the pointer at requester 1.
    cola0.push_back(pet(1'b1, 1, 8'h5A));
    inactivo(6);

    // Read by requester 1 aborted by reset in ESPERA: no ack, pointer back to 0.
    cola1.push_back(pet(1'b0, 3, 0));
    ciclo(1'b0);
    ciclo(1'b0);
    ciclo(1'b1);
    inactivo(3);

    // Contention straight after reset: requester 0 goes first, then they alternate.
    cola0.push_back(pet(1'b1, 0, 8'h11));
    cola1.push_back(pet(1'b1, 1, 8'h22));
    cola0.push_back(pet(1'b0, 0, 0));
    cola1.push_back(pet(1'b0, 1, 0));
    inactivo(24);

    // Single write, single read and address error.
    cola0.push_back(pet(1'b1, 2, 8'hA5));
    inactivo(6);
    cola1.push_back(pet(1'b0, 4, 0));
    inactivo(7);
    check("leido1_3c", 32'(leido1), 32'h3C);
    cola0.push_back(pet(1'b1, 7, 8'hFF));
    inactivo(5);

    // Random traffic from both requesters, with one reset in the middle.
    for (int k = 0; k < 1500; k++) begin
      if (cola0.size() == 0 && $urandom_range(0, 2) == 0) cola0.push_back(pet_aleatoria());
      if (cola1.size() == 0 && $urandom_range(0, 2) == 0) cola1.push_back(pet_aleatoria());
      ciclo(k == 700);
    end

    // Drain: every raised request must have been answered.
    inactivo(20);
    check("drenado", 32'(activo[0]) + 32'(activo[1]) + 32'(cola0.size()) + 32'(cola1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
